ir_pipe_stage: RTL

Parametrised instruction pipeline register with a valid/ready handshake, a one-entry skid buffer, synchronous flush-to-NOP, and a debug instruction-injection port. It sits between any two core pipeline stages (IF→ID, ID→EX, …) and is the standard inter-stage holding register. It absorbs one cycle of downstream back-pressure without a combinational ready path from out_ready to in_ready. The external debugger uses it to slip single instructions into the stream.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/ir_pipe_stage.sv | 119 +++++++++++
 2 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage instruction pipeline register.
// The state enum mirrors the (main_valid, skid_valid) occupancy of the stage.
package pipe_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/ir_pipe_stage.sv
// Instruction pipeline register with a one-entry skid buffer, flush-to-NOP and
// a debug injection port that takes priority over the upstream stage.
module ir_pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter logic [31:0] NOP_VALUE = RV_NOP,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             inject_valid,
  input  logic [WIDTH-1:0] inject_data,
  output logic             inject_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [WIDTH-1:0] NOP_W = WIDTH'(NOP_VALUE);

  pipe_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0] stall_q;

  logic             main_valid;
  logic             skid_valid;
  logic             acc;
  logic             out_fire;
  logic [WIDTH-1:0] acc_word;

  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == SKID);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      main_data_q <= NOP_W;
      skid_data_q <= NOP_W;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

  // Injection wins the single accept slot; the upstream word waits a cycle.
  always_comb begin
    acc      = (in_valid & in_ready) | (inject_valid & inject_ready);
    acc_word = (inject_valid & inject_ready) ? inject_data : in_data;
    out_fire = out_valid & out_ready;
  end

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = EMPTY;
      main_data_d = NOP_W;
      skid_data_d = NOP_W;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d     = FULL;
            main_data_d = acc_word;
          end
        end
        FULL: begin
          if (out_fire && acc) begin
            main_data_d = acc_word;
          end else if (out_fire) begin
            state_d = EMPTY;
          end else if (acc) begin
            state_d     = SKID;
            skid_data_d = acc_word;
          end
        end
        SKID: begin
          if (out_fire) begin
            state_d     = FULL;
            main_data_d = skid_data_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Readies look only at registered occupancy and inject_valid, never at out_ready.
  always_comb begin
    inject_ready = ~skid_valid;
    in_ready     = ~skid_valid & ~inject_valid;
    out_valid    = main_valid;
    out_data     = main_valid ? main_data_q : NOP_W;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_count = stall_q;

  assert property (@(posedge clk) disable iff (!reset_n) !(!main_valid && skid_valid));

endmodule
